seg_scan_drv: RTL and testbench
===============================

# seg_scan_drv

Time-multiplexed seven-segment scan driver, the stage directly downstream of the signed binary-to-BCD display front end. Accepts a packed BCD digit vector plus a sign code, double-buffers them so the display never tears mid-frame, and drives one digit enable and the shared segment bus per scan slot. Leading zeros are optionally blanked. Outputs go straight to board pins.

## Interface
- `DIGITS`, 2: BCD magnitude digits; total scan slots = DIGITS+1 (sign slot on top)
- `DIV`, 50000: clk cycles per scan slot, ≥2
- `LZB`, 1: 1 = blank leading zeros, 0 = show all digits

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `bcd`  in  4*DIGITS  digit codes, `bcd[3:0]` least significant
- `bcd_sgn`  in  4  sign slot code: 4'hA minus, 4'hF blank
- `load`  in  1  one-cycle strobe capturing `bcd`/`bcd_sgn` into shadow
- `pending`  out  1  shadow holds data not yet shown
- `frame`  out  1  one-cycle pulse on each frame start
- `an`  out  DIGITS+1  digit enables, active-low one-hot; `an[0]` = LS digit, `an[DIGITS]` = sign
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Code map: 0–9 decimal glyphs; 4'hA minus (g only, 7'b0111111); 4'hB–4'hF blank (7'b1111111). '0'=7'b1000000, '1'=7'b1111001.
- Shadow register: `load` writes shadow, sets `pending`. Repeated `load` before apply: last wins.
- Display register: copied from shadow at frame start if `pending`; `pending` clears unless `load` is high in that same cycle (then shadow takes new value, `pending` stays 1, previously shadowed value is applied).
- Divider `div_cnt` counts 0..DIV-1; `tick` at DIV-1. On tick `slot` advances 0→1→…→DIGITS→0. Wrap to 0 is frame start: `frame` pulses, apply occurs.
- LZB=1: digit i (i≥1) blanked if it and every higher magnitude digit are 0; digit 0 never blanked. Sign slot unaffected by LZB, stays leftmost. Only codes 0–9 count as zero-tests; non-digit codes stop suppression.
- States: implicit scan over slots; no idle state, scan runs continuously.

## Timing
- Reset values: `div_cnt`=0, `slot`=0, display register all 4'hF (digits and sign), shadow all 4'hF, `pending`=0, `frame`=0, `an`=all 1, `seg`=7'h7F.
- `an`/`seg` registered: reflect `slot` and display register with 1-cycle latency; first clock edge after reset release drives `an` = ~1 (slot 0), `seg` blank.
- Slot dwell exactly DIV cycles; frame period (DIGITS+1)*DIV.
- `load` to visible: at most (DIGITS+1)*DIV+1 cycles; `pending` high from cycle after `load` until cycle after apply.
- `frame` asserted in the cycle after the wrapping tick (aligned with `an` switching to slot 0).
- Reset mid-scan: all state returns to reset values immediately; no partial frame completion.
- `bcd`/`bcd_sgn` sampled only on `load`; changes otherwise ignored.

## Structure
- Package `seg_pkg`: code constants CODE_MINUS=4'hA, CODE_BLANK=4'hF; segment constants SEG_BLANK, SEG_MINUS, digit glyph table.
- Sub-module `seg7_dec`: combinational 4-bit code → 7-bit active-low segments; instantiated once on the slot-selected code.
- Top holds divider, slot counter, shadow/display registers, LZB mask, output registers.

## Test plan
- Reset, DIV=4, DIGITS=2, no load: `an` cycles 3'b110→101→011 every 4 cycles, `seg`=7'h7F throughout, `frame` every 12 cycles.
- `load` bcd=8'h07, sgn=4'hA, LZB=1: after next frame, slot0 seg=7'b1111000, slot1 blank, slot2 7'b0111111; `pending` 1→0 at apply.
- Same with LZB=0: slot1 shows '0' (7'b1000000).
- Two `load`s (8'h12 then 8'h34) within one frame: only 34 displayed, never 12.
- `load` coincident with frame apply: earlier shadow shown this frame, new value next frame, `pending` stays 1 across apply.
- Assert `rst_n` low mid-slot 1 with data shown: `an`=all 1, `seg`=7'h7F, `pending`=0 asynchronously; scan restarts at slot 0 blank.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared code and segment constants for the seven-segment scan driver
package seg_pkg;
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_MINUS  = 7'b0111111;
    // active-low {g,f,e,d,c,b,a} glyphs, entry n is decimal digit n
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: 4-bit display code to active-low seven-segment pattern
module seg7_dec
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    // digits map to glyphs, minus lights g only, anything else is dark
    always_comb
        seg = (code < 4'd10) ? SEG_DIGIT[code] : (code == CODE_MINUS) ? SEG_MINUS : SEG_BLANK;
endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: double-buffered, time-multiplexed seven-segment scan driver
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DIV    = 50000,
    parameter bit LZB    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [3:0]            bcd_sgn,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame,
    output logic [DIGITS:0]       an,
    output logic [6:0]            seg
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = (DIGITS > 0) ? $clog2(DIGITS + 1) : 1;
    localparam logic [DIGITS:0] ONE = 1;

    logic [DW-1:0]          div_cnt;
    logic [SW-1:0]          slot;
    logic                   tick, wrap, wrap_q, lead;
    logic [DIGITS-1:0][3:0] sh_dig, dp_dig;
    logic [3:0]             sh_sgn, dp_sgn, code;
    logic [DIGITS-1:0]      blank;
    logic [DIGITS:0][3:0]   slot_code;
    logic [6:0]             seg_d;

    assign tick = div_cnt == DW'(DIV - 1);
    assign wrap = tick && slot == SW'(DIGITS);
    assign code = slot_code[slot];

    // slot dwell divider, slot counter, and frame pulse delayed to line up with an
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            div_cnt <= '0;
            slot    <= '0;
            wrap_q  <= 1'b0;
            frame   <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            slot    <= !tick ? slot : wrap ? '0 : slot + 1'b1;
            wrap_q  <= wrap;
            frame   <= wrap_q;
        end

    // shadow captures on load; display takes the shadow only at frame start so a frame never tears
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh_dig  <= {DIGITS{CODE_BLANK}};
            sh_sgn  <= CODE_BLANK;
            dp_dig  <= {DIGITS{CODE_BLANK}};
            dp_sgn  <= CODE_BLANK;
            pending <= 1'b0;
        end else begin
            if (load) begin
                sh_dig <= bcd;
                sh_sgn <= bcd_sgn;
            end
            if (wrap && pending) begin
                dp_dig <= sh_dig;
                dp_sgn <= sh_sgn;
            end
            pending <= load || (pending && !wrap);
        end

    // leading-zero run walked down from the top digit; digit 0 always shows
    always_comb begin
        blank = '0;
        lead  = LZB;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead && dp_dig[i] == 4'h0;
            blank[i] = lead;
        end
        slot_code[DIGITS] = dp_sgn;
        for (int i = 0; i < DIGITS; i++)
            slot_code[i] = blank[i] ? CODE_BLANK : dp_dig[i];
    end

    seg7_dec u_dec (
        .code (code),
        .seg  (seg_d)
    );

    // registered pin drivers, one cycle behind the slot counter
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(ONE << slot);
            seg <= seg_d;
        end
endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: directed checks of scan timing, buffering, blanking and reset
module tb_seg_scan_drv;
    logic       clk = 1'b0, rst_n = 1'b1, load = 1'b0;
    logic [7:0] bcd = 8'h00;
    logic [3:0] bcd_sgn = 4'hF;
    logic       pending, frame, pending0, frame0;
    logic [2:0] an, an0;
    logic [6:0] seg, seg0;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    seg_scan_drv #(.DIGITS(2), .DIV(4), .LZB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .bcd_sgn(bcd_sgn), .load(load),
        .pending(pending), .frame(frame), .an(an), .seg(seg)
    );

    seg_scan_drv #(.DIGITS(2), .DIV(4), .LZB(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .bcd_sgn(bcd_sgn), .load(load),
        .pending(pending0), .frame(frame0), .an(an0), .seg(seg0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [7:0] v, input logic [3:0] s);
        bcd = v;
        bcd_sgn = s;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!frame && n < 40);
        check("frame_wait", frame, 1);
    endtask

    task automatic slots(input string tag, input logic [6:0] s0, s1, s2, t0, t1, t2);
        check({tag, "_an0"}, an, 3'b110);
        check({tag, "_s0"}, seg, s0);
        check({tag, "_s0_nolzb"}, seg0, t0);
        step(4);
        check({tag, "_an1"}, an, 3'b101);
        check({tag, "_s1"}, seg, s1);
        check({tag, "_s1_nolzb"}, seg0, t1);
        step(4);
        check({tag, "_an2"}, an, 3'b011);
        check({tag, "_s2"}, seg, s2);
        check({tag, "_s2_nolzb"}, seg0, t2);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_an", an, 3'b111);
        check("rst_seg", seg, 7'h7F);
        check("rst_pending", pending, 0);
        check("rst_frame", frame, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // idle scan: slot every 4 cycles, frame every 12, nothing lit
        for (int k = 1; k <= 36; k++) begin
            logic [2:0] ea;
            step(1);
            ea = ~(3'b001 << (((k - 1) / 4) % 3));
            check("idle_an", an, ea);
            check("idle_frame", frame, (k > 1 && (k - 1) % 12 == 0));
            check("idle_seg", seg, 7'h7F);
            check("idle_seg_nolzb", seg0, 7'h7F);
        end
        // -07: leading zero blanked only with LZB
        ld(8'h07, 4'hA);
        check("lz_pending_set", pending, 1);
        wait_frame();
        check("lz_pending_clr", pending, 0);
        slots("lz07", 7'h78, 7'h7F, 7'h3F, 7'h78, 7'h40, 7'h3F);
        // two loads in one frame: last wins
        wait_frame();
        ld(8'h12, 4'hF);
        step(1);
        ld(8'h34, 4'hF);
        check("dbl_pending", pending, 1);
        wait_frame();
        slots("dbl34", 7'h19, 7'h30, 7'h7F, 7'h19, 7'h30, 7'h7F);
        // load on the wrapping edge: older shadow shows now, new one next frame
        wait_frame();
        ld(8'h56, 4'hA);
        step(9);
        ld(8'h89, 4'hA);
        check("co_pending_hold", pending, 1);
        step(1);
        check("co_frame", frame, 1);
        check("co_pending_after", pending, 1);
        slots("co56", 7'h02, 7'h12, 7'h3F, 7'h02, 7'h12, 7'h3F);
        wait_frame();
        check("co_pending_clr", pending, 0);
        slots("co89", 7'h10, 7'h00, 7'h3F, 7'h10, 7'h00, 7'h3F);
        // asynchronous reset mid slot 1 with data on display
        wait_frame();
        step(4);
        check("pre_rst_an", an, 3'b101);
        check("pre_rst_seg", seg, 7'h00);
        ld(8'h11, 4'hF);
        check("pre_rst_pending", pending, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_an", an, 3'b111);
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_an_nolzb", an0, 3'b111);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("post_rst_an0", an, 3'b110);
        check("post_rst_seg0", seg, 7'h7F);
        step(4);
        check("post_rst_an1", an, 3'b101);
        check("post_rst_seg1", seg, 7'h7F);
        check("post_rst_seg1_nolzb", seg0, 7'h7F);
        check("post_rst_pending", pending, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
